// File: rtl/nlc_pkg.sv
// Shared constants and types for the NLC front end.
package nlc_pkg;

  localparam int XW              = 21;
  localparam int TIMEOUT_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module sample_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic [AW:0]  level_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty     = (wptr_r == rptr_r);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rptr_r[AW-1:0]];
  assign level     = level_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      level_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array; emptiness is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_sample_feeder.sv
// Deserialises the ADC serial stream, queues samples and hands them to the
// NLC one at a time, with a completion watchdog and sticky status flags.
module adc_sample_feeder
  import nlc_pkg::*;
#(
  parameter int XW         = nlc_pkg::XW,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_adc_bit_en,
  input  logic          i_adc_sdata,
  input  logic          i_adc_frame,
  input  logic          i_srdyo,
  output logic [XW-1:0] o_x,
  output logic          o_srdyi,
  output logic [2:0]    o_fifo_level,
  output logic          o_overflow,
  output logic          o_frame_err,
  output logic          o_timeout
);

  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT);

  state_e          state_r;
  logic [4:0]      bit_cnt_r;
  logic [XW-1:0]   shreg_r;
  logic [XW-1:0]   x_r;
  logic            srdyi_r;
  logic [WDW-1:0]  wdog_r;
  logic            overflow_r;
  logic            frame_err_r;
  logic            timeout_r;
  logic            word_done_s;
  logic [XW-1:0]   word_s;
  logic            pop_s;
  logic [XW-1:0]   fifo_dout_s;
  logic [LW-1:0]   fifo_level_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [WDW-1:0]  wdog_nxt_s;

  // The completing bit is written straight into the FIFO at the same edge
  assign word_s      = {shreg_r[XW-2:0], i_adc_sdata};
  assign word_done_s = i_adc_bit_en && !i_adc_frame && (bit_cnt_r == 5'(XW-1));
  assign pop_s       = !fifo_empty_s && ((state_r == IDLE) || ((state_r == WAIT) && i_srdyo));
  assign wdog_nxt_s  = wdog_r + WDW'(1);

  sample_fifo #(.W(XW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (word_done_s),
    .pop   (pop_s),
    .din   (word_s),
    .dout  (fifo_dout_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Serial-to-parallel conversion and framing check
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt_r   <= 5'd0;
      shreg_r     <= '0;
      frame_err_r <= 1'b0;
    end else if (i_adc_bit_en) begin
      if (i_adc_frame) begin
        if (bit_cnt_r != 5'd0) frame_err_r <= 1'b1;
        shreg_r   <= {{(XW-1){1'b0}}, i_adc_sdata};
        bit_cnt_r <= 5'd1;
      end else if (bit_cnt_r != 5'd0) begin
        shreg_r   <= word_s;
        bit_cnt_r <= word_done_s ? 5'd0 : bit_cnt_r + 5'd1;
      end
    end
  end

  // Sticky drop flag: a finished word found no room and nothing left the FIFO
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_r <= 1'b0;
    end else if (word_done_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Issue FSM with watchdog; a completion in WAIT can issue the next sample at once
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= IDLE;
      x_r       <= '0;
      srdyi_r   <= 1'b0;
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            x_r     <= fifo_dout_s;
            srdyi_r <= 1'b1;
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          srdyi_r <= 1'b0;
          wdog_r  <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (i_srdyo) begin
            if (pop_s) begin
              x_r     <= fifo_dout_s;
              srdyi_r <= 1'b1;
              state_r <= ISSUE;
            end else begin
              state_r <= IDLE;
            end
          end else if (wdog_nxt_s == WDW'(TIMEOUT-1)) begin
            timeout_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            wdog_r <= wdog_nxt_s;
          end
        end
        default: begin
          srdyi_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_x          = x_r;
  assign o_srdyi      = srdyi_r;
  assign o_fifo_level = 3'(fifo_level_s);
  assign o_overflow   = overflow_r;
  assign o_frame_err  = frame_err_r;
  assign o_timeout    = timeout_r;

endmodule
